// File: rtl/sbd_sqrt_shift_ctrl.sv
// Sequencing controller for the SBD square-root datapath: loads the aligned
// mantissa, shifts in one root digit per handshake, then normalises right.
module sbd_sqrt_shift_ctrl #(
  parameter int unsigned bitlength = 48,
  parameter int unsigned ITER      = 16,
  parameter int unsigned NORM_MAX  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [bitlength-1:0] MANT,
  input  logic                 ODD_EXP,
  input  logic [2:0]           DIGIT_IN,
  input  logic                 DIGIT_VLD,
  output logic                 DIGIT_RDY,
  input  logic [bitlength-1:0] SH_POUT,
  output logic [bitlength-1:0] SH_PIN,
  output logic                 SH_LOAD,
  output logic                 SH_LR,
  output logic                 SH_SHIFT,
  output logic [2:0]           SH_SINLSB,
  output logic [1:0]           SH_SINMSB,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           NORM_CNT
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam int unsigned NC_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_NORM,
    ST_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [bitlength-1:0] op_q, op_d;
  logic [CNT_W-1:0]     dig_cnt_q, dig_cnt_d;
  logic [NC_W-1:0]      norm_cnt_q, norm_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_q, load_d;
  logic                 top_set_c;
  logic                 norm_go_c;
  logic                 unused_pout_c;

  // Only the two MSBs of the shifter contents steer normalisation.
  assign unused_pout_c = ^SH_POUT[bitlength-3:0];
  assign top_set_c     = |SH_POUT[bitlength-1 -: 2];
  assign norm_go_c     = top_set_c && (norm_cnt_q < NC_W'(NORM_MAX));

  // Next-state logic; shifter strobes follow the handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dig_cnt_d  = dig_cnt_q;
    norm_cnt_d = norm_cnt_q;
    DIGIT_RDY  = 1'b0;
    SH_SHIFT   = 1'b0;
    SH_LR      = 1'b0;
    SH_SINLSB  = 3'b000;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_d       = ODD_EXP ? {MANT[bitlength-2:0], 1'b0} : MANT;
          dig_cnt_d  = '0;
          norm_cnt_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: begin
        DIGIT_RDY = 1'b1;
        if (DIGIT_VLD) begin
          SH_SHIFT  = 1'b1;
          SH_SINLSB = DIGIT_IN;
          dig_cnt_d = dig_cnt_q + CNT_W'(1);
          if (dig_cnt_q == CNT_W'(ITER - 1)) begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (norm_go_c) begin
          SH_SHIFT   = 1'b1;
          SH_LR      = 1'b1;
          norm_cnt_d = norm_cnt_q + NC_W'(1);
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_ITER) || (state_d == ST_NORM);
    done_d = (state_d == ST_FIN);
    load_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      dig_cnt_q  <= '0;
      norm_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dig_cnt_q  <= dig_cnt_d;
      norm_cnt_q <= norm_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_q     <= load_d;
    end
  end

  assign SH_PIN    = op_q;
  assign SH_LOAD   = load_q;
  assign SH_SINMSB = 2'b00;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign NORM_CNT  = norm_cnt_q;

endmodule

// File: tb/tb_sbd_sqrt_shift_ctrl.sv
// Directed bench for sbd_sqrt_shift_ctrl with a behavioural 3-left/2-right
// shift register closing the loop on SH_POUT.
module tb_sbd_sqrt_shift_ctrl;

  localparam int unsigned BL     = 48;
  localparam int unsigned ITER_N = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [BL-1:0] MANT;
  logic          ODD_EXP;
  logic [2:0]    DIGIT_IN;
  logic          DIGIT_VLD;
  logic          DIGIT_RDY;
  logic [BL-1:0] pout;
  logic [BL-1:0] SH_PIN;
  logic          SH_LOAD, SH_LR, SH_SHIFT;
  logic [2:0]    SH_SINLSB;
  logic [1:0]    SH_SINMSB;
  logic          BUSY, DONE;
  logic [2:0]    NORM_CNT;

  logic [BL-1:0] sh_q;
  logic          force_en;
  logic [1:0]    force_top;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sbd_sqrt_shift_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .MANT(MANT), .ODD_EXP(ODD_EXP),
    .DIGIT_IN(DIGIT_IN), .DIGIT_VLD(DIGIT_VLD), .DIGIT_RDY(DIGIT_RDY),
    .SH_POUT(pout), .SH_PIN(SH_PIN), .SH_LOAD(SH_LOAD), .SH_LR(SH_LR),
    .SH_SHIFT(SH_SHIFT), .SH_SINLSB(SH_SINLSB), .SH_SINMSB(SH_SINMSB),
    .BUSY(BUSY), .DONE(DONE), .NORM_CNT(NORM_CNT)
  );

  // Shift register model; top bits can be overridden to steer normalisation.
  always @(posedge CLK) begin
    if (RST)           sh_q <= '0;
    else if (SH_LOAD)  sh_q <= SH_PIN;
    else if (SH_SHIFT) sh_q <= SH_LR ? {SH_SINMSB, sh_q[BL-1:2]} : {sh_q[BL-4:0], SH_SINLSB};
  end
  assign pout = force_en ? {force_top, sh_q[BL-3:0]} : sh_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation; fmode 0 = real shifter, 1 = top bits 11,01,00, 2 = top bits stuck at 11.
  task automatic run_op(input string nm, input logic [BL-1:0] mant, input logic odd,
                        input logic [2:0] dig, input bit stall, input int fmode,
                        input bit fin_start, input logic [BL-1:0] exp_pin,
                        input int exp_rsh, input int exp_done, input logic [BL-1:0] exp_sh);
    int n, r, nf, loads, lsh, rsh, bad, done_at, rdy, late;
    logic [BL-1:0] pin_seen;
    n = 0; r = 0; nf = 0; loads = 0; lsh = 0; rsh = 0; bad = 0; done_at = 0; rdy = 0; late = 0;
    pin_seen = '0;
    @(posedge CLK); #1;
    START = 1'b1; MANT = mant; ODD_EXP = odd; DIGIT_IN = dig; DIGIT_VLD = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0; MANT = '0; ODD_EXP = 1'b0;
    while (done_at == 0 && n < 200) begin
      n++;
      DIGIT_VLD = 1'b1;
      if (DIGIT_RDY) begin
        DIGIT_VLD = stall ? (r % 3 == 0) : 1'b1;
        r++;
      end
      force_en = (fmode != 0) && (lsh == ITER_N);
      if (fmode == 2)      force_top = 2'b11;
      else if (nf == 0)    force_top = 2'b11;
      else if (nf == 1)    force_top = 2'b01;
      else                 force_top = 2'b00;
      if (force_en) nf++;
      @(negedge CLK);
      if (SH_LOAD) begin loads++; pin_seen = SH_PIN; end
      if (SH_LOAD && SH_SHIFT) bad++;
      if (SH_SHIFT && !SH_LR) begin
        lsh++;
        if (SH_SINLSB !== dig || !DIGIT_VLD || !DIGIT_RDY) bad++;
      end
      if (SH_SHIFT && SH_LR) begin
        rsh++;
        if (SH_SINMSB !== 2'b00 || DIGIT_RDY) bad++;
      end
      if (!SH_SHIFT && DIGIT_RDY && DIGIT_VLD) bad++;
      if (DIGIT_RDY) rdy++;
      if (!BUSY && !DONE) bad++;
      if (DONE) begin
        done_at = n;
        if (fin_start) START = 1'b1;
      end
      @(posedge CLK); #1;
    end
    START = 1'b0; DIGIT_VLD = 1'b0; force_en = 1'b0;
    chk({nm, ".loads"},    64'(loads),   64'd1);
    chk({nm, ".pin"},      64'(pin_seen), 64'(exp_pin));
    chk({nm, ".lshifts"},  64'(lsh),     64'(ITER_N));
    chk({nm, ".rshifts"},  64'(rsh),     64'(exp_rsh));
    chk({nm, ".protocol"}, 64'(bad),     64'd0);
    chk({nm, ".rdy_cyc"},  64'(rdy),     stall ? 64'd46 : 64'd16);
    chk({nm, ".done_cyc"}, 64'(done_at), 64'(exp_done));
    chk({nm, ".norm_cnt"}, 64'(NORM_CNT), 64'(exp_rsh));
    chk({nm, ".shifter"},  64'(sh_q),    64'(exp_sh));
    chk({nm, ".pulse"},    64'({BUSY, DONE}), 64'd0);
    if (fin_start) begin
      repeat (3) begin
        @(negedge CLK);
        if (SH_LOAD || BUSY || DONE) late++;
      end
      chk({nm, ".fin_start"}, 64'(late), 64'd0);
      chk({nm, ".cnt_hold"},  64'(NORM_CNT), 64'(exp_rsh));
    end
  endtask

  initial begin
    int n, lsh, stray;
    RST = 1'b1; START = 1'b0; MANT = '0; ODD_EXP = 1'b0;
    DIGIT_IN = 3'b000; DIGIT_VLD = 1'b0; force_en = 1'b0; force_top = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.outs", 64'({DIGIT_RDY, SH_LOAD, SH_LR, SH_SHIFT, SH_SINLSB, SH_SINMSB, BUSY, DONE, NORM_CNT}), 64'd0);
    chk("rst.pin",  64'(SH_PIN), 64'd0);
    RST = 1'b0;

    run_op("basic", 48'h400000000000, 1'b0, 3'b001, 1'b0, 0, 1'b0,
           48'h400000000000, 0, 19, 48'h249249249249);
    run_op("odd",   48'h200000000000, 1'b1, 3'b010, 1'b0, 0, 1'b0,
           48'h400000000000, 1, 20, 48'h124924924924);
    run_op("stall", 48'h800000000000, 1'b0, 3'b111, 1'b1, 0, 1'b0,
           48'h800000000000, 1, 50, 48'h3fffffffffff);
    run_op("norm",  48'h400000000000, 1'b0, 3'b001, 1'b0, 1, 1'b0,
           48'h400000000000, 2, 21, 48'h024924924924);
    run_op("sat",   48'h400000000000, 1'b0, 3'b001, 1'b0, 2, 1'b0,
           48'h400000000000, 3, 22, 48'h009249249249);

    // Abort mid-iteration after five accepted digits.
    @(posedge CLK); #1;
    START = 1'b1; MANT = 48'h123456789abc; DIGIT_IN = 3'b101; DIGIT_VLD = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    n = 0; lsh = 0;
    while (lsh < 5 && n < 50) begin
      @(negedge CLK);
      if (SH_SHIFT) lsh++;
      n++;
    end
    chk("abort.digits", 64'(lsh), 64'd5);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort.outs", 64'({DIGIT_RDY, SH_LOAD, SH_SHIFT, BUSY, DONE, NORM_CNT}), 64'd0);
    chk("abort.pin",  64'(SH_PIN), 64'd0);
    chk("abort.shreg", 64'(sh_q), 64'd0);
    stray = 0;
    repeat (2) begin
      @(negedge CLK);
      if (DONE || BUSY || SH_LOAD) stray++;
    end
    chk("abort.quiet", 64'(stray), 64'd0);
    DIGIT_VLD = 1'b0;
    run_op("rerun", 48'h400000000000, 1'b0, 3'b001, 1'b0, 0, 1'b1,
           48'h400000000000, 0, 19, 48'h249249249249);

    // Reset beats a simultaneous START.
    @(posedge CLK); #1;
    RST = 1'b1; START = 1'b1; MANT = 48'h400000000000;
    @(posedge CLK); #1;
    RST = 1'b0; START = 1'b0;
    chk("rst_start", 64'({BUSY, SH_LOAD, DONE}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
